// File: rtl/seq_det_pkg.sv
// Shared types and default widths for the configurable serial pattern detector.
// Optional abort input is enabled with `define SEQ_DET_ABORT_EN (see seq_det_scan_ctrl).
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_PAT_W_MAX = 8;
  localparam int DEF_LEN_W     = 4;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/seq_det_pat_match.sv
// Bit history, fill tracking and match compare for the serial pattern detector.
// match is combinational on the post-shift history; the caller registers it.
module seq_det_pat_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W_MAX = DEF_PAT_W_MAX,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic                 bit_in,
  input  logic [PAT_W_MAX-1:0] pat,
  input  logic [LEN_W-1:0]     len,
  input  logic                 ovl,
  output logic                 match
);

  logic [PAT_W_MAX-1:0] hist, hist_nx, mask;
  logic [LEN_W-1:0]     fill, fill_nx, len_eff;

  // Lengths beyond the history depth are clamped; mask selects the low len_eff bits.
  always_comb begin
    len_eff = (len > LEN_W'(PAT_W_MAX)) ? LEN_W'(PAT_W_MAX) : len;
    hist_nx = {hist[PAT_W_MAX-2:0], bit_in};
    fill_nx = (fill == LEN_W'(PAT_W_MAX)) ? fill : fill + 1'b1;
    mask    = '0;
    for (int i = 0; i < PAT_W_MAX; i++) begin
      mask[i] = (LEN_W'(i) < len_eff);
    end
    match = shift_en && (len_eff != '0) && (fill_nx >= len_eff) &&
            ((hist_nx & mask) == (pat & mask));
  end

  // Non-overlapping mode restarts the fill so the next match needs fresh bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_nx;
      fill <= (match && !ovl) ? '0 : fill_nx;
    end
  end

endmodule

// File: rtl/seq_det_scan_ctrl.sv
// Framed word serialiser driving a run-time configurable pattern detector.
// Define SEQ_DET_ABORT_EN to add the abort input that cancels a frame in LOAD/SHIFT.
module seq_det_scan_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PAT_W_MAX = DEF_PAT_W_MAX,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [PAT_W_MAX-1:0] cfg_pat,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_ovl,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
`ifdef SEQ_DET_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 in_ready,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 hit,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t               state, state_nx;
  logic [PAT_W_MAX-1:0] pat_q;
  logic [LEN_W-1:0]     len_q;
  logic                 ovl_q;
  logic [DATA_W-1:0]    word_q;
  logic                 last_q;
  logic [IDX_W-1:0]     idx;
  logic                 abort_req;
  logic                 frame_start;
  logic                 match;

`ifdef SEQ_DET_ABORT_EN
  assign abort_req = abort && ((state == LOAD) || (state == SHIFT));
`else
  assign abort_req = 1'b0;
`endif

  assign frame_start = (state == IDLE) && start;

  assign in_ready  = (state == LOAD);
  assign bit_valid = (state == SHIFT);
  assign bit_out   = bit_valid && word_q[idx];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Abort outranks the handshake so a word offered alongside abort is dropped.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (abort_req) state_nx = IDLE;
               else if (in_valid) state_nx = SHIFT;
      SHIFT:   if (abort_req) state_nx = IDLE;
               else if (idx == '0) state_nx = last_q ? DONE : LOAD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      word_q    <= '0;
      last_q    <= 1'b0;
      idx       <= '0;
      hit       <= 1'b0;
      match_cnt <= '0;
    end else begin
      state <= state_nx;
      hit   <= match;
      if (frame_start) begin
        pat_q <= cfg_pat;
        len_q <= cfg_len;
        ovl_q <= cfg_ovl;
      end
      if ((state == LOAD) && in_valid && !abort_req) begin
        word_q <= in_data;
        last_q <= in_last;
        idx    <= IDX_W'(DATA_W - 1);
      end else if (state == SHIFT) begin
        idx <= idx - 1'b1;
      end
      // Count tracks hit and saturates; it is only cleared by the next frame start.
      if (frame_start) begin
        match_cnt <= '0;
      end else if (match && (match_cnt != '1)) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

  seq_det_pat_match #(
    .PAT_W_MAX (PAT_W_MAX),
    .LEN_W     (LEN_W)
  ) u_match (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (frame_start || abort_req),
    .shift_en (bit_valid && !abort_req),
    .bit_in   (bit_out),
    .pat      (pat_q),
    .len      (len_q),
    .ovl      (ovl_q),
    .match    (match)
  );

endmodule

// File: tb/tb_seq_det_scan_ctrl.sv
// Self-checking bench for seq_det_scan_ctrl: directed table, reset/abort sequences, random frames.
// Abort sequences are built when SEQ_DET_ABORT_EN is defined.
module tb_seq_det_scan_ctrl;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  cfg_pat;
  logic [3:0]  cfg_len;
  logic        cfg_ovl;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready, bit_out, bit_valid, hit, busy, done;
  logic [7:0]  match_cnt;
  logic        in_ready2, bit_out2, bit_valid2, hit2, busy2, done2;
  logic [1:0]  match_cnt2;
`ifdef SEQ_DET_ABORT_EN
  logic        abort;
`endif

  int tests = 0;
  int fails = 0;

  logic        exp_bits[$];
  int          exp_pos[$];
  int          hit_pos[$];
  logic [15:0] frame_words[4];
  int          bit_cnt, prev_pos, done_cnt, done_cyc, ser_err, cyc, hs_cyc;

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    int          nwords;
    logic [15:0] w0;
    logic [15:0] w1;
    int          gap;
    int          exp_hits;
  } vec_t;

  vec_t vecs[8];

  seq_det_scan_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
`ifdef SEQ_DET_ABORT_EN
    .abort(abort),
`endif
    .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid), .hit(hit),
    .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  seq_det_scan_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .start(start), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
`ifdef SEQ_DET_ABORT_EN
    .abort(abort),
`endif
    .in_ready(in_ready2), .bit_out(bit_out2), .bit_valid(bit_valid2), .hit(hit2),
    .match_cnt(match_cnt2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // A hit belongs to the bit that was on bit_out in the previous cycle.
  always @(negedge clk) begin
    if (hit) hit_pos.push_back(prev_pos);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bit_valid) begin
      if (bit_cnt >= exp_bits.size()) ser_err++;
      else if (bit_out !== exp_bits[bit_cnt]) ser_err++;
      prev_pos = bit_cnt;
      bit_cnt++;
    end else begin
      prev_pos = -1;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan the bit list window by window; non-overlap forbids windows reaching into a prior match.
  function automatic void modelHits(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    int leff, next_start;
    bit ok;
    exp_pos.delete();
    leff = (len > 8) ? 8 : int'(len);
    next_start = 0;
    if (leff == 0) return;
    for (int p = 0; p < exp_bits.size(); p++) begin
      if (p - leff + 1 >= next_start) begin
        ok = 1;
        for (int k = 0; k < leff; k++)
          if (exp_bits[p - leff + 1 + k] !== pat[leff - 1 - k]) ok = 0;
        if (ok) begin
          exp_pos.push_back(p);
          if (!ovl) next_start = p + 1;
        end
      end
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                               input int nwords, input int gap);
    int k;
    exp_bits.delete();
    for (int w = 0; w < nwords; w++)
      for (int b = 15; b >= 0; b--) exp_bits.push_back(frame_words[w][b]);
    modelHits(pat, len, ovl);
    @(negedge clk);
    cfg_pat = pat; cfg_len = len; cfg_ovl = ovl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit_pos.delete();
    bit_cnt = 0; prev_pos = -1; done_cnt = 0; done_cyc = -1; ser_err = 0;
    for (int w = 0; w < nwords; w++) begin
      k = 0;
      while (!in_ready && k < 100) begin @(negedge clk); k++; end
      checkOutput("ready_timeout", (k >= 100), 0);
      for (int g = 0; g < gap; g++) @(negedge clk);
      in_valid = 1'b1; in_data = frame_words[w]; in_last = (w == nwords - 1);
      @(posedge clk); #1;
      hs_cyc = cyc;
      in_valid = 1'b0; in_last = 1'b0;
    end
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    checkOutput("done_timeout", (k >= 100), 0);
    #1;
  endtask

  task automatic checkFrame(input string tag);
    int diffs, n;
    n = exp_pos.size();
    diffs = (hit_pos.size() == n) ? 0 : 1;
    for (int i = 0; i < n && i < hit_pos.size(); i++)
      if (hit_pos[i] != exp_pos[i]) diffs++;
    checkOutput({tag, "_serial"}, ser_err, 0);
    checkOutput({tag, "_hitpos"}, diffs, 0);
    checkOutput({tag, "_cnt"}, match_cnt, (n > 255) ? 255 : n);
    checkOutput({tag, "_cnt2"}, match_cnt2, (n > 3) ? 3 : n);
    checkOutput({tag, "_done"}, done_cnt, 1);
    checkOutput({tag, "_donelat"}, done_cyc - hs_cyc, 16);
  endtask

  initial begin
    vecs[0] = '{8'h05, 4'd3,  1'b1, 1, 16'hA800, 16'h0000, 0, 2};
    vecs[1] = '{8'hE5, 4'd3,  1'b0, 1, 16'hA800, 16'h0000, 0, 1};
    vecs[2] = '{8'h06, 4'd3,  1'b1, 1, 16'hDB00, 16'h0000, 0, 3};
    vecs[3] = '{8'h05, 4'd3,  1'b1, 2, 16'h0002, 16'h8000, 0, 1};
    vecs[4] = '{8'h05, 4'd3,  1'b1, 2, 16'h0002, 16'h8000, 5, 1};
    vecs[5] = '{8'h05, 4'd0,  1'b1, 1, 16'hA800, 16'h0000, 0, 0};
    vecs[6] = '{8'hFF, 4'd12, 1'b1, 1, 16'hFF00, 16'h0000, 0, 1};
    vecs[7] = '{8'h01, 4'd1,  1'b1, 1, 16'hF800, 16'h0000, 0, 5};

    rstn = 1'b0; start = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
`ifdef SEQ_DET_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    checkOutput("reset_flags", {busy, bit_valid, bit_out, in_ready, hit, done}, 0);
    checkOutput("reset_cnt", match_cnt, 0);
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    checkOutput("idle_flags", {busy, bit_valid, in_ready, done}, 0);

    for (int i = 0; i < 8; i++) begin
      frame_words[0] = vecs[i].w0;
      frame_words[1] = vecs[i].w1;
      applyStimulus(vecs[i].pat, vecs[i].len, vecs[i].ovl, vecs[i].nwords, vecs[i].gap);
      checkOutput($sformatf("tbl%0d_hits", i), hit_pos.size(), vecs[i].exp_hits);
      checkFrame($sformatf("tbl%0d", i));
    end

    // Reset in the middle of SHIFT must clear everything at once and never emit done.
    @(negedge clk);
    cfg_pat = 8'h05; cfg_len = 4'd3; cfg_ovl = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'hA800; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_pre_cnt", match_cnt, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_flags", {busy, bit_valid, bit_out, in_ready, hit, done}, 0);
    checkOutput("rst_cnt", match_cnt, 0);
    done_cnt = 0;
    @(negedge clk) rstn = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("rst_nodone", done_cnt, 0);
    checkOutput("rst_idle", busy, 0);

`ifdef SEQ_DET_ABORT_EN
    @(negedge clk);
    cfg_pat = 8'h05; cfg_len = 4'd3; cfg_ovl = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'hA800; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1; done_cnt = 0;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_idle", busy, 0);
    checkOutput("abort_cnt", match_cnt, 1);
    repeat (20) @(negedge clk);
    checkOutput("abort_nodone", done_cnt, 0);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checkOutput("abort_prio", {busy, bit_valid}, 0);
`endif

    for (int r = 0; r < 30; r++) begin
      logic [7:0] rp;
      logic [3:0] rl;
      int         nw;
      rp = 8'($urandom);
      rl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) frame_words[w] = 16'($urandom);
      applyStimulus(rp, rl, 1'($urandom), nw, $urandom_range(0, 3));
      checkFrame($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
